// File: rtl/serial_frame_rx_if.sv
// Serial receive link bundle: line input toward the receiver, parallel word
// and status strobes back toward the datapath.
interface serial_frame_rx_if #(
    parameter int unsigned DATA_W = 5
);
    logic              rx_in;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx_in,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_in,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Asynchronous serial receiver: idle-high line, one start bit, DATA_W data
// bits LSB-first, one stop bit, all timed by a BIT_CYCLES bit-period counter.
module serial_frame_rx #(
    parameter int unsigned BIT_CYCLES = 8,
    parameter int unsigned DATA_W     = 5
) (
    input logic            CLOCK_50,
    input logic            RESET_N,
    serial_frame_rx_if.slave bus
);
    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF     = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LAST     = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_busy;
    logic              w_rs;

    assign w_rs = r_sync2;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= bus.rx_in;
            r_sync2     <= r_sync1;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rs) begin
                        // cnt starts at 1 so the mid-bit sample lands HALF cycles after t0
                        r_state <= S_START;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt <= '0;
                        if (!w_rs) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        // shifting in from the top leaves the first bit at bit 0
                        r_shift <= {w_rs, r_shift[DATA_W-1:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (w_rs) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: frames are driven bit-serially and the
// expected pulse (kind, data, cycle) is queued and matched when it appears.
module tb_serial_frame_rx;
    localparam int unsigned BC   = 8;
    localparam int unsigned HALF = BC / 2;
    // 2 sync cycles to t0, HALF to start sample, 6 bit periods to stop sample, +1 for the pulse
    localparam int unsigned LAT  = 2 + HALF + 6 * BC + 1;

    typedef struct {
        logic        is_err;
        logic [4:0]  d;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [4:0]  last_good;
    exp_t        sb[$];
    exp_t        mon_e;

    serial_frame_rx_if #(.DATA_W(5)) bus ();

    serial_frame_rx #(
        .BIT_CYCLES(BC),
        .DATA_W    (5)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid === 1'b1 || bus.frame_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'b0, bus.valid, bus.frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {30'b0, bus.valid, bus.frame_err}, mon_e.is_err ? 32'd1 : 32'd2);
                check("pulse_data", {27'b0, bus.data}, {27'b0, mon_e.d});
                check("pulse_cycle", cyc, mon_e.at);
                if (!mon_e.is_err) check("busy_at_valid", {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    // Caller must be at a negedge; the task ends at the negedge after the stop bit.
    task automatic send_frame(input logic [4:0] d, input logic stop, input bit chk_busy);
        exp_t       e;
        logic [6:0] bits;
        bits     = {stop, d, 1'b0};
        e.is_err = !stop;
        e.d      = stop ? d : last_good;
        e.at     = cyc + LAT;
        if (stop) last_good = d;
        sb.push_back(e);
        for (int b = 0; b < 7; b++) begin
            bus.rx_in = bits[b];
            for (int k = 1; k <= int'(BC); k++) begin
                @(negedge clk);
                if (chk_busy && b == 0 && k == 2) check("busy_at_t0", {31'b0, bus.busy}, 32'd0);
                if (chk_busy && b == 0 && k == 3) check("busy_rise", {31'b0, bus.busy}, 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        bus.rx_in = 1'b0;
        last_good = 5'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        bus.rx_in = 1'b1;
        check("reset_data", {27'b0, bus.data}, 32'd0);
        check("reset_valid", {31'b0, bus.valid}, 32'd0);
        check("reset_ferr", {31'b0, bus.frame_err}, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);

        // single frame
        send_frame(5'b10110, 1'b1, 1'b1);
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("single_data", {27'b0, bus.data}, 32'h16);
        check("single_drained", sb.size(), 32'd0);

        // false start: two low cycles only
        repeat (10) @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("false_start_busy", {31'b0, bus.busy}, 32'd1);
        repeat (8) @(negedge clk);
        check("false_start_idle", {31'b0, bus.busy}, 32'd0);
        check("false_start_data", {27'b0, bus.data}, 32'h16);

        // framing error, then held low
        repeat (5) @(negedge clk);
        send_frame(5'b00011, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("wait_high_busy", {31'b0, bus.busy}, 32'd1);
        check("ferr_data_kept", {27'b0, bus.data}, 32'h16);
        bus.rx_in = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_high_exit", {31'b0, bus.busy}, 32'd0);
        send_frame(5'b11111, 1'b1, 1'b0);
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("after_ferr_data", {27'b0, bus.data}, 32'h1f);

        // back-to-back
        repeat (5) @(negedge clk);
        send_frame(5'b00001, 1'b1, 1'b0);
        send_frame(5'b11110, 1'b1, 1'b0);
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("b2b_data", {27'b0, bus.data}, 32'h1e);

        // reset in the middle of DATA (idx==2)
        repeat (5) @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (8) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (8) @(negedge clk);
        bus.rx_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_data", {27'b0, bus.data}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_valid", {31'b0, bus.valid}, 32'd0);
        check("midrst_ferr", {31'b0, bus.frame_err}, 32'd0);
        last_good = 5'b0;
        rst_n     = 1'b1;
        bus.rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_idle", {31'b0, bus.busy}, 32'd0);
        send_frame(5'b01010, 1'b1, 1'b0);
        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_data", {27'b0, bus.data}, 32'h0a);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
